sensor_fetch: RTL
=================

Name: sensor_fetch

Overview:
- Consumer side of the I2C sensor ready-flag interface.
- Watches the sticky acc/gyro/mag ready flags and arbitrates round-robin among pending sensors.
- Reads the granted sensor's X/Y/Z words from the shared sample register file, then pulses that sensor's read strobe to clear its flag.
- Presents one complete 3-axis sample to the Kalman filter front end over a valid/ready handshake.

Parameters:
- DATA_W, 16, width of one axis word.
- TS_W, 16, width of the timestamp counter. Used only with SENSOR_FETCH_TS_EN.

Ports:
- clk, in, 1, system clock.
- n_rst, in, 1, asynchronous active-low reset.
- acc_ready, in, 1, sticky accelerometer data-ready flag.
- gyro_ready, in, 1, sticky gyroscope data-ready flag.
- mag_ready, in, 1, sticky magnetometer data-ready flag.
- acc_read, out, 1, one-cycle strobe that clears acc_ready.
- gyro_read, out, 1, one-cycle strobe that clears gyro_ready.
- mag_read, out, 1, one-cycle strobe that clears mag_ready.
- rd_sel, out, 2, register-file sensor select: 0 = acc, 1 = gyro, 2 = mag.
- rd_axis, out, 2, register-file axis select: 0 = X, 1 = Y, 2 = Z.
- rd_data, in, DATA_W, register-file read data. It is valid one cycle after rd_sel/rd_axis.
- out_valid, out, 1, sample available.
- out_ready, in, 1, downstream accepts the sample.
- out_sensor, out, 2, sensor code of the sample.
- out_x, out, DATA_W, X axis word.
- out_y, out, DATA_W, Y axis word.
- out_z, out, DATA_W, Z axis word.
- out_ts, out, TS_W, capture timestamp. Present only with SENSOR_FETCH_TS_EN.

Behaviour:
- Reset is asynchronous on n_rst low, clock is clk. Reset values:
  - FSM = IDLE, cnt = 0.
  - All read strobes = 0, rd_sel = 0, rd_axis = 0.
  - out_valid = 0, out_sensor = 0, out_x/out_y/out_z = 0, out_ts = 0.
  - Round-robin pointer last = 2 (mag), so acc has first priority after reset.
- IDLE:
  - rd_sel = 0 and rd_axis = 0.
  - If any flag is high, grant the first pending sensor in the order last+1, last+2, last+3 (mod 3).
  - Latch grant into sel_q, set last = grant, set cnt = 0, go to FETCH.
  - If no flag is high, stay in IDLE.
- FETCH (exactly 4 cycles, cnt 0..3):
  - rd_sel = sel_q throughout.
  - For cnt 0..2: rd_axis = cnt. For cnt 3: rd_axis = 2 (don't-care but stable).
  - At cnt 1, 2, 3: capture rd_data into X, Y, Z respectively.
  - At cnt 3: assert the read strobe of sel_q for that single cycle only, then go to PRESENT.
- PRESENT:
  - out_valid = 1; out_sensor/out_x/out_y/out_z are stable and unchanged while out_valid && !out_ready.
  - When out_valid && out_ready: deassert out_valid next cycle and return to IDLE.
  - No new grant is made in PRESENT; flags raised meanwhile stay pending in the flag unit.
- Latency:
  - Flag sampled high in IDLE at edge t → read strobe during cycle t+4 → out_valid from cycle t+5.
  - Minimum back-to-back period: 6 cycles per sample with out_ready held high.
- Flag clearing: the flag clears on the edge after the strobe. The earliest re-arbitration is 2 cycles later, so a just-read sensor is never granted twice on a stale flag.
- Simultaneous flags: all three high continuously → grant order acc, gyro, mag, acc, …
- A flag re-asserting for the same sensor while PRESENT is held is serviced normally after the handshake, subject to round-robin order.
- Reset mid-FETCH: no strobe is issued. The flag stays set and the sensor is re-fetched from axis X after reset.
- Reset during PRESENT: the sample is dropped and out_valid = 0 immediately (asynchronous).
- No arithmetic beyond the 2-bit cnt and the mod-3 pointer. Encoding 3 on rd_sel/out_sensor never occurs.

Optional Feature:
- Macro: SENSOR_FETCH_TS_EN.
- When defined:
  - A free-running TS_W-bit counter increments every cycle from 0 after reset, wrapping 2^TS_W-1 → 0.
  - Its value is latched at grant time (IDLE→FETCH transition) and driven on out_ts, held with the sample.
- When undefined: no counter, no out_ts port, identical behaviour otherwise.

Test Plan:
- Reset then acc_ready=1 at edge t; register file returns acc X/Y/Z = 16'h1111/16'h2222/16'h3333 → acc_read=1 in cycle t+4 only; out_valid at t+5 with out_sensor=0 and X/Y/Z 16'h1111/16'h2222/16'h3333.
- All three flags held high, out_ready=1 → samples in order sensor 0, 1, 2, 0, each spaced 6 cycles; each strobe fires exactly once per sample.
- gyro sample presented with out_ready=0 for 10 cycles → outputs stable, no strobes, rd_sel=0; raising out_ready → out_valid falls next cycle.
- n_rst pulsed low at FETCH cnt=2 for mag → no mag_read; after release, mag is fetched again starting at axis X and delivered correctly.
- mag_ready re-asserts one cycle after mag_read while PRESENT is held → a second mag sample follows after the handshake; no duplicate from the stale flag.
- SENSOR_FETCH_TS_EN defined, flag raised when counter=16'hFFFE → out_ts=16'hFFFE; counter wraps to 0 two cycles later.

Source files
------------

// File: rtl/sensor_fetch.sv
// sensor_fetch: round-robin consumer of the acc/gyro/mag ready flags; fetches X/Y/Z words and hands one sample downstream.
// Optional build macro SENSOR_FETCH_TS_EN adds a free-running timestamp latched at grant and driven on out_ts.
`default_nettype none

module sensor_fetch #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              acc_ready,
    input  logic              gyro_ready,
    input  logic              mag_ready,
    output logic              acc_read,
    output logic              gyro_read,
    output logic              mag_read,
    output logic [1:0]        rd_sel,
    output logic [1:0]        rd_axis,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_sensor,
`ifdef SENSOR_FETCH_TS_EN
    output logic [TS_W-1:0]   out_ts,
`endif
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic [DATA_W-1:0] out_z
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;
    logic [1:0]        r_sel;
    logic [1:0]        r_last;
    logic [1:0]        w_p1;
    logic [1:0]        w_p2;
    logic [1:0]        w_grant;
    logic              w_any;
    logic              w_take;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_z;

    function automatic logic pending(input logic [1:0] idx, input logic a, input logic g, input logic m);
        case (idx)
            2'd0:    pending = a;
            2'd1:    pending = g;
            2'd2:    pending = m;
            default: pending = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] next_mod3(input logic [1:0] v);
        case (v)
            2'd0:    next_mod3 = 2'd1;
            2'd1:    next_mod3 = 2'd2;
            default: next_mod3 = 2'd0;
        endcase
    endfunction

    // Search order last+1, last+2, last (mod 3) gives fair round-robin
    always_comb begin
        w_p1    = next_mod3(r_last);
        w_p2    = next_mod3(w_p1);
        w_any   = acc_ready | gyro_ready | mag_ready;
        w_grant = r_last;
        if (pending(w_p1, acc_ready, gyro_ready, mag_ready)) begin
            w_grant = w_p1;
        end else if (pending(w_p2, acc_ready, gyro_ready, mag_ready)) begin
            w_grant = w_p2;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        rd_sel      = 2'd0;
        rd_axis     = 2'd0;
        acc_read    = 1'b0;
        gyro_read   = 1'b0;
        mag_read    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_sel    = r_sel;
                rd_axis   = (r_cnt == 2'd3) ? 2'd2 : r_cnt;
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    acc_read    = (r_sel == 2'd0);
                    gyro_read   = (r_sel == 2'd1);
                    mag_read    = (r_sel == 2'd2);
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Register-file reads have one cycle of latency, so axis n lands at cnt n+1
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sel  <= 2'd0;
            r_last <= 2'd2;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
        end else begin
            if (w_take) begin
                r_sel  <= w_grant;
                r_last <= w_grant;
            end
            if (r_state == S_FETCH) begin
                case (r_cnt)
                    2'd1:    r_x <= rd_data;
                    2'd2:    r_y <= rd_data;
                    2'd3:    r_z <= rd_data;
                    default: ;
                endcase
            end
        end
    end

    assign out_sensor = r_sel;
    assign out_x      = r_x;
    assign out_y      = r_y;
    assign out_z      = r_z;

`ifdef SENSOR_FETCH_TS_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ts_cnt <= '0;
            r_ts     <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_take) begin
                r_ts <= r_ts_cnt;
            end
        end
    end

    assign out_ts = r_ts;
`else
    logic [TS_W-1:0] w_ts_unused;
    assign w_ts_unused = '0;
`endif

endmodule

`default_nettype wire
